// File: rtl/reg_file_pkg.sv
// Shared types and constants for the integer register file and its scoreboard.
package reg_file_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef logic [4:0]          reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } busy_state_e;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy tracking: alloc sets, writeback clears, alloc wins a tie.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid_i,
  input  logic [AW-1:0]              alloc_addr_i,
  input  logic [NWR-1:0][NREGS-1:0]  clr_i,
  output logic [NREGS-1:0]           busy_vec_o,
  output logic [AW:0]                pending_cnt_o
);

  busy_state_e       st_q [NREGS];
  busy_state_e       st_d [NREGS];
  logic [NREGS-1:0]  clr_any;
  logic [AW:0]       cnt_q, cnt_d;

  always_comb begin
    clr_any = '0;
    for (int unsigned l = 0; l < NWR; l++) clr_any = clr_any | clr_i[l];

    cnt_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      st_d[r] = st_q[r];
      if (r == 0)
        st_d[r] = IDLE;
      else if (alloc_valid_i && alloc_addr_i == AW'(r))
        st_d[r] = BUSY;
      else if (clr_any[r])
        st_d[r] = IDLE;
      // count is taken from the next state so it always matches the registered busy bits
      if (st_d[r] == BUSY) cnt_d = cnt_d + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) st_q[r] <= IDLE;
      cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) st_q[r] <= st_d[r];
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy_vec_o = '0;
    for (int unsigned r = 0; r < NREGS; r++) busy_vec_o[r] = (st_q[r] == BUSY);
  end

  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with scoreboard; x0 hardwired to zero.
// Optional same-cycle write forwarding on reads: REG_FILE_WRITE_BYPASS_EN.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRD-1:0][AW-1:0]     rd_addr,
  output logic [NRD-1:0][XLEN-1:0]   rd_data,
  output logic [NRD-1:0]             rd_busy,
  input  logic                       alloc_valid,
  input  logic [AW-1:0]              alloc_addr,
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR-1:0][AW-1:0]     wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]   wr_data,
  output logic [NREGS-1:0]           busy_vec,
  output logic [AW:0]                pending_cnt
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [XLEN-1:0]           regs_q [NREGS];
  logic [NWR-1:0][NREGS-1:0] clr;

  // Ascending lane order: the last non-blocking write wins, so the highest lane has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int unsigned l = 0; l < NWR; l++)
        if (wr_en[l] && wr_addr[l] != ZERO_A) regs_q[wr_addr[l]] <= wr_data[l];
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < NWR; l++) begin
      clr[l] = '0;
      if (wr_en[l] && wr_addr[l] != ZERO_A) clr[l][wr_addr[l]] = 1'b1;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid_i (alloc_valid),
    .alloc_addr_i  (alloc_addr),
    .clr_i         (clr),
    .busy_vec_o    (busy_vec),
    .pending_cnt_o (pending_cnt)
  );

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_data[i] = (rd_addr[i] == ZERO_A) ? '0 : regs_q[rd_addr[i]];
      rd_busy[i] = busy_vec[rd_addr[i]];
`ifdef REG_FILE_WRITE_BYPASS_EN
      for (int unsigned l = 0; l < NWR; l++) begin
        if (wr_en[l] && wr_addr[l] == rd_addr[i] && rd_addr[i] != ZERO_A) begin
          rd_data[i] = wr_data[l];
          rd_busy[i] = alloc_valid && (alloc_addr == rd_addr[i]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic vs. a model.
module tb_reg_file_sb;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     alloc_valid;
  logic [AW-1:0]            alloc_addr;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic [NREGS-1:0]         busy_vec;
  logic [AW:0]              pending_cnt;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy_vec(busy_vec), .pending_cnt(pending_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain array of values and a set of busy registers.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REG_FILE_WRITE_BYPASS_EN
    for (int l = NWR - 1; l >= 0; l--)
      if (wr_en[l] && wr_addr[l] == a) return wr_data[l];
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_WRITE_BYPASS_EN
    for (int l = 0; l < NWR; l++)
      if (wr_en[l] && wr_addr[l] == a) return alloc_valid && alloc_addr == a;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [NREGS-1:0] exp_vec();
    logic [NREGS-1:0] v = '0;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  task automatic idle();
    rst = 1'b0; alloc_valid = 1'b0; alloc_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  // Advance one clock, apply the architectural rules to the model, settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
    end else begin
      for (int l = 0; l < NWR; l++)
        if (wr_en[l] && wr_addr[l] != 0) begin
          m_regs[wr_addr[l]] = wr_data[l];
          m_busy[wr_addr[l]] = 0;
        end
      if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); idle();
    rd_addr[0] = 5'd31; rd_addr[1] = 5'd1; #1;
    n_checks++; if (rd_data[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rd31 got %h exp 0", rd_data[0]); end
    n_checks++; if (rd_data[1] !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp 0", rd_data[1]); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b exp 00", rd_busy); end
    n_checks++; if (pending_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", pending_cnt); end
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_vec got %h exp 0", busy_vec); end
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; tick(); idle();
    rd_addr[0] = 5'd5; #1;
    n_checks++; if (rd_data[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_x5 got %h exp deadbeef", rd_data[0]); end
  endtask

  task automatic test_x0();
    idle(); wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
    alloc_valid = 1'b1; alloc_addr = 5'd0; tick(); idle();
    rd_addr[0] = 5'd0; #1;
    n_checks++; if (rd_data[0] !== 32'h0) begin n_fail++; $display("FAIL x0_data got %h exp 0", rd_data[0]); end
    n_checks++; if (busy_vec[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b exp 0", busy_vec[0]); end
    n_checks++; if (pending_cnt !== 6'd0) begin n_fail++; $display("FAIL x0_cnt got %0d exp 0", pending_cnt); end
  endtask

  task automatic test_collision();
    idle(); wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; rd_addr[0] = 5'd7; #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    n_checks++; if (rd_data[0] !== 32'h22) begin n_fail++; $display("FAIL coll_bypass got %h exp 22", rd_data[0]); end
`else
    n_checks++; if (rd_data[0] !== 32'h0) begin n_fail++; $display("FAIL coll_old got %h exp 0", rd_data[0]); end
`endif
    tick(); idle(); #1;
    n_checks++; if (rd_data[0] !== 32'h22) begin n_fail++; $display("FAIL coll_x7 got %h exp 22", rd_data[0]); end
  endtask

  task automatic test_alloc_clear();
    idle(); alloc_valid = 1'b1; alloc_addr = 5'd3; tick();
    n_checks++; if (pending_cnt !== 6'd1) begin n_fail++; $display("FAIL alloc3_cnt got %0d exp 1", pending_cnt); end
    alloc_addr = 5'd4; tick();
    n_checks++; if (pending_cnt !== 6'd2) begin n_fail++; $display("FAIL alloc4_cnt got %0d exp 2", pending_cnt); end
    alloc_addr = 5'd3; wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h12345678; tick(); idle();
    rd_addr[0] = 5'd3; #1;
    n_checks++; if (busy_vec[3] !== 1'b1) begin n_fail++; $display("FAIL tie_busy3 got %b exp 1", busy_vec[3]); end
    n_checks++; if (pending_cnt !== 6'd2) begin n_fail++; $display("FAIL tie_cnt got %0d exp 2", pending_cnt); end
    n_checks++; if (rd_data[0] !== 32'h12345678) begin n_fail++; $display("FAIL tie_data got %h exp 12345678", rd_data[0]); end
    wr_en = 2'b11; wr_addr[0] = 5'd3; wr_addr[1] = 5'd4; tick(); idle();
    n_checks++; if (pending_cnt !== 6'd0) begin n_fail++; $display("FAIL retire_cnt got %0d exp 0", pending_cnt); end
  endtask

  task automatic test_fill();
    idle(); alloc_valid = 1'b1;
    for (int a = 1; a < NREGS; a++) begin alloc_addr = AW'(a); tick(); end
    idle();
    n_checks++; if (pending_cnt !== 6'd31) begin n_fail++; $display("FAIL fill_cnt got %0d exp 31", pending_cnt); end
    n_checks++; if (busy_vec !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL fill_vec got %h exp fffffffe", busy_vec); end
    alloc_valid = 1'b1; alloc_addr = 5'd9; tick(); idle();
    n_checks++; if (pending_cnt !== 6'd31) begin n_fail++; $display("FAIL waw_cnt got %0d exp 31", pending_cnt); end
    rst = 1'b1; wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'h55;
    alloc_valid = 1'b1; alloc_addr = 5'd6; tick(); idle();
    rd_addr[0] = 5'd5; #1;
    n_checks++; if (pending_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", pending_cnt); end
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL rst_vec got %h exp 0", busy_vec); end
    n_checks++; if (rd_data[0] !== 32'h0) begin n_fail++; $display("FAIL rst_discard got %h exp 0", rd_data[0]); end
  endtask

  task automatic test_bypass();
    idle(); alloc_valid = 1'b1; alloc_addr = 5'd9; tick(); idle();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'hA5A5A5A5; rd_addr[1] = 5'd9; #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    n_checks++; if (rd_data[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL byp_data got %h exp a5a5a5a5", rd_data[1]); end
    n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL byp_busy got %b exp 0", rd_busy[1]); end
`else
    n_checks++; if (rd_data[1] !== 32'h0) begin n_fail++; $display("FAIL nobyp_data got %h exp 0", rd_data[1]); end
    n_checks++; if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL nobyp_busy got %b exp 1", rd_busy[1]); end
`endif
    tick(); idle(); #1;
    n_checks++; if (rd_data[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL byp_next_data got %h exp a5a5a5a5", rd_data[1]); end
    n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL byp_next_busy got %b exp 0", rd_busy[1]); end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 79) == 0);
      alloc_valid = ($urandom_range(0, 2) != 0);
      alloc_addr  = rnd_addr();
      for (int l = 0; l < NWR; l++) begin
        wr_en[l]   = ($urandom_range(0, 1) == 1);
        wr_addr[l] = rnd_addr();
        wr_data[l] = $urandom;
      end
      for (int i = 0; i < NRD; i++) rd_addr[i] = rnd_addr();
      #1;
      if (!rst) begin
        for (int i = 0; i < NRD; i++) begin
          n_checks++;
          if (rd_data[i] !== exp_data(rd_addr[i])) begin
            n_fail++; $display("FAIL rand_rd_data cyc %0d port %0d addr %0d got %h exp %h", c, i, rd_addr[i], rd_data[i], exp_data(rd_addr[i]));
          end
          n_checks++;
          if (rd_busy[i] !== exp_busy(rd_addr[i])) begin
            n_fail++; $display("FAIL rand_rd_busy cyc %0d port %0d addr %0d got %b exp %b", c, i, rd_addr[i], rd_busy[i], exp_busy(rd_addr[i]));
          end
        end
      end
      tick();
      n_checks++;
      if (busy_vec !== exp_vec()) begin n_fail++; $display("FAIL rand_vec cyc %0d got %h exp %h", c, busy_vec, exp_vec()); end
      n_checks++;
      if (pending_cnt !== (AW+1)'(exp_cnt())) begin n_fail++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", c, pending_cnt, exp_cnt()); end
    end
    idle();
  endtask

  initial begin
    idle(); rd_addr = '0;
    for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
    test_reset();
    test_x0();
    test_collision();
    test_alloc_clear();
    test_fill();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
